// File: rtl/stream_selector.sv
// N-channel valid/ready stream selector with manual or round-robin choice,
// packet-level locking and a single registered output slot.
module stream_selector #(
  parameter int CH    = 4,
  parameter int WIDTH = 8,
  localparam int SEL_W = $clog2(CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic [CH-1:0]       in_valid,
  input  logic [CH*WIDTH-1:0] in_data,
  input  logic [CH-1:0]       in_last,
  output logic [CH-1:0]       in_ready,
  output logic                out_valid,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_last,
  output logic [SEL_W-1:0]    out_ch,
  input  logic                out_ready,
  output logic                busy
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]       state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] lock_ch;
  logic [SEL_W-1:0] g;
  logic [SEL_W-1:0] g_next;
  logic             cand_ok;
  logic             load_en;
  logic             accept;
  int               idx;

  always_comb begin
    g       = '0;
    cand_ok = 1'b0;
    idx     = 0;
    if (state == LOCKED) begin
      g       = lock_ch;
      cand_ok = 1'b1;
    end else if (!mode) begin
      g       = sel;
      cand_ok = (int'(sel) < CH);
    end else begin
      // first valid channel scanning from ptr, wrapping modulo CH
      for (int unsigned i = 0; i < CH; i++) begin
        idx = int'(ptr) + int'(i);
        if (idx >= CH) idx = idx - CH;
        if (!cand_ok && in_valid[idx]) begin
          g       = SEL_W'(idx);
          cand_ok = 1'b1;
        end
      end
    end
  end

  always_comb begin
    load_en  = !out_valid || out_ready;
    in_ready = '0;
    if (load_en && cand_ok && rst_n) in_ready[g] = 1'b1;
    accept   = load_en && cand_ok && rst_n && in_valid[g];
    g_next   = (int'(g) == CH - 1) ? '0 : g + SEL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      lock_ch   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= in_data[int'(g)*WIDTH +: WIDTH];
        out_last  <= in_last[g];
        out_ch    <= g;
        if (in_last[g]) begin
          ptr   <= g_next;
          state <= IDLE;
        end else if (state == IDLE) begin
          state   <= LOCKED;
          lock_ch <= g;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (state == LOCKED);

endmodule

// File: tb/tb_stream_selector.sv
// Directed, table-driven bench for stream_selector (CH=4, WIDTH=8).
module tb_stream_selector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic [1:0]  out_ch;
  logic        out_ready;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  stream_selector #(.CH(4), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ch(out_ch), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  last;
    logic        ordy;
    logic [3:0]  er;
    logic        eov;
    logic [7:0]  ed;
    logic [1:0]  ech;
    logic        eb;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // in_ready checked before the edge, registered outputs checked after it
  task automatic cycle(input string nm, input logic [3:0] er, input logic eov,
                       input logic [7:0] ed, input logic [1:0] ech, input logic eb);
    @(negedge clk);
    chk({nm, ".in_ready"}, 32'(in_ready), 32'(er));
    @(posedge clk);
    #1;
    chk({nm, ".out_valid"}, 32'(out_valid), 32'(eov));
    chk({nm, ".out_data"}, 32'(out_data), 32'(ed));
    chk({nm, ".out_ch"}, 32'(out_ch), 32'(ech));
    chk({nm, ".busy"}, 32'(busy), 32'(eb));
  endtask

  initial begin
    //            mode sel valid   data          last    ordy er      eov ed     ech eb
    tbl[0]  = '{1'b1, 2'd0, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 2'd0, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1, 1'b0};
    tbl[2]  = '{1'b1, 2'd0, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2, 1'b0};
    tbl[3]  = '{1'b1, 2'd0, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3, 1'b0};
    tbl[4]  = '{1'b1, 2'd0, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0, 1'b0};
    tbl[5]  = '{1'b0, 2'd2, 4'b0110, 32'h00119900, 4'b0000, 1'b1, 4'b0100, 1'b1, 8'h11, 2'd2, 1'b1};
    tbl[6]  = '{1'b0, 2'd2, 4'b0110, 32'h00229900, 4'b0000, 1'b1, 4'b0100, 1'b1, 8'h22, 2'd2, 1'b1};
    tbl[7]  = '{1'b0, 2'd2, 4'b0110, 32'h00339900, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2, 1'b0};
    tbl[8]  = '{1'b0, 2'd2, 4'b0000, 32'h00000000, 4'b0000, 1'b1, 4'b0100, 1'b0, 8'h33, 2'd2, 1'b0};
    tbl[9]  = '{1'b1, 2'd0, 4'b0010, 32'h0000B100, 4'b0000, 1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1, 1'b1};
    tbl[10] = '{1'b0, 2'd3, 4'b1010, 32'hC300B200, 4'b1000, 1'b1, 4'b0010, 1'b1, 8'hB2, 2'd1, 1'b1};
    tbl[11] = '{1'b0, 2'd3, 4'b1000, 32'hC300B200, 4'b1000, 1'b1, 4'b0010, 1'b0, 8'hB2, 2'd1, 1'b1};
    tbl[12] = '{1'b0, 2'd3, 4'b1010, 32'hC300B300, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'hB3, 2'd1, 1'b0};
    tbl[13] = '{1'b0, 2'd3, 4'b1000, 32'hC3000000, 4'b1000, 1'b1, 4'b1000, 1'b1, 8'hC3, 2'd3, 1'b0};

    rst_n = 1'b0; mode = 1'b1; sel = '0; in_valid = 4'b1111;
    in_data = 32'hA3A2A1A0; in_last = 4'b1111; out_ready = 1'b1;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.out_data", 32'(out_data), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("rst.in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      mode = tbl[i].mode; sel = tbl[i].sel; in_valid = tbl[i].valid;
      in_data = tbl[i].data; in_last = tbl[i].last; out_ready = tbl[i].ordy;
      cycle($sformatf("vec%0d", i), tbl[i].er, tbl[i].eov, tbl[i].ed, tbl[i].ech, tbl[i].eb);
    end

    // back-pressure: 5A held for 5 stalled cycles, then ch1 (ptr=1) follows
    mode = 1'b1; in_valid = 4'b0001; in_data = 32'h0000005A; in_last = 4'b1111; out_ready = 1'b1;
    cycle("bp.load", 4'b0001, 1'b1, 8'h5A, 2'd0, 1'b0);
    in_valid = 4'b0011; in_data = 32'h00007766; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) cycle("bp.stall", 4'b0000, 1'b1, 8'h5A, 2'd0, 1'b0);
    out_ready = 1'b1;
    cycle("bp.resume", 4'b0010, 1'b1, 8'h77, 2'd1, 1'b0);
    in_valid = 4'b0000;
    cycle("bp.drain", 4'b0000, 1'b0, 8'h77, 2'd1, 1'b0);

    // reset during a ch2 packet (ptr=2), then ptr must restart at 0
    in_valid = 4'b0100; in_data = 32'h00D10000; in_last = 4'b0000;
    cycle("mrst.start", 4'b0100, 1'b1, 8'hD1, 2'd2, 1'b1);
    rst_n = 1'b0;
    cycle("mrst.reset", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    rst_n = 1'b1; in_valid = 4'b0101; in_data = 32'h00D200E0; in_last = 4'b0101;
    cycle("mrst.resume", 4'b0001, 1'b1, 8'hE0, 2'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_selector.md
# stream_selector

Parametrised N-channel, W-bit stream selector: the registered, handshaked successor to the 2:1 single-bit selector. It picks one of CH valid/ready input streams per packet, either from a manual select input or by round-robin arbitration. It holds the selection for the whole packet and delivers one beat per cycle through a single output register. It sits between multiple producer blocks (UART RX, sensor front-ends, test pattern generators) and a single consumer.

## Interface
- CH, 4, number of input channels (2..16)
- WIDTH, 8, data bits per channel
- SEL_W, $clog2(CH), derived localparam, not overridable
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- mode  in  1  0 = manual (use sel), 1 = round-robin
- sel  in  SEL_W  channel index in manual mode
- in_valid  in  CH  per-channel beat valid
- in_data  in  CH*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
- in_last  in  CH  per-channel end-of-packet flag
- in_ready  out  CH  per-channel accept, at most one bit high
- out_valid  out  1  output register holds a beat
- out_data  out  WIDTH  registered beat data
- out_last  out  1  registered end-of-packet flag
- out_ch  out  SEL_W  source channel of current output beat
- out_ready  in  1  consumer accept
- busy  out  1  packet in progress (LOCKED state)

## Operation
- Two states:
  - IDLE: no packet open.
  - LOCKED: packet open on lock_ch.
- load_en = !out_valid | out_ready. The output slot is free, or it is being drained this cycle.
- Candidate channel g:
  - LOCKED: g = lock_ch. mode and sel are ignored.
  - IDLE, mode 0: g = sel. There is no candidate if sel >= CH.
  - IDLE, mode 1: g = the first channel with in_valid set, scanning ptr, ptr+1, … modulo CH.
- in_ready[g] = load_en & candidate exists & rst_n. All other in_ready bits are 0. in_ready may depend combinationally on out_ready.
- A beat is accepted when in_valid[g] & in_ready[g]. On acceptance:
  - out_data ← in_data[g]
  - out_last ← in_last[g]
  - out_ch ← g
  - out_valid ← 1
- If out_ready=1 and no beat is accepted, out_valid ← 0. The data, last and ch fields hold their values.
- State transitions:
  - IDLE, beat accepted with last=0 → LOCKED, lock_ch ← g.
  - IDLE, beat accepted with last=1 → stays IDLE (single-beat packet).
  - LOCKED, beat accepted with last=1 → IDLE.
- Whenever a beat with last=1 is accepted: ptr ← (g+1) mod CH. This wraps correctly for non-power-of-2 CH; e.g. CH=3, g=2 gives ptr 0.
- ptr changes only on an accepted last beat, in both modes. A manual-mode packet therefore also advances the round-robin start point.
- If in_valid[lock_ch] drops while LOCKED, the block stays LOCKED and waits. Other channels are never granted mid-packet.
- mode/sel changes while LOCKED take effect only after returning to IDLE.
- busy = (state == LOCKED).

## Timing
- Reset (rst_n=0 at a clock edge) sets: out_valid 0, out_data 0, out_last 0, out_ch 0, busy 0, state IDLE, ptr 0, lock_ch 0.
- in_ready is 0 while rst_n=0.
- Reset mid-packet drops the lock and discards any beat held in the output register.
- Latency: a beat accepted at edge N is presented at out_valid after edge N.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- Back-pressure: while out_valid=1 and out_ready=0, all in_ready are 0 and the output fields are stable.
- Drain and refill in the same cycle (out_ready=1 with a new beat accepted) keeps out_valid=1 with no bubble.
- Round-robin with all channels valid and single-beat packets grants 0,1,2,3,0,… in successive cycles.

## Test plan
- Reset then idle:
  - Hold rst_n=0 for 3 cycles with all in_valid=1.
  - Required: in_ready=0000, out_valid=0, out_data=0x00, busy=0 throughout.
  - After release, mode=1, the first grant is channel 0.
- Manual 3-beat packet:
  - mode=0, sel=2, ch2 sends 0x11, 0x22, 0x33 (last on 0x33), ch1 valid throughout, out_ready=1.
  - Required: out_data 0x11, 0x22, 0x33 on consecutive cycles, out_ch=2, busy=1 for 2 cycles.
  - ch1 is never readied.
- Round-robin fairness:
  - mode=1, all 4 channels valid with single-beat packets, data = 0xA0+ch.
  - Required: out_data sequence A0, A1, A2, A3, A0 with no bubbles.
- Lock holds across mode/sel change:
  - Start a ch1 packet in mode 1, then switch to mode=0, sel=3 mid-packet.
  - Required: the remaining beats come from ch1.
  - After ch1's last beat, ch3 is granted next.
- Back-pressure and stall:
  - out_ready=0 for 5 cycles while out_valid=1 with out_data=0x5A.
  - Required: out_data stays 0x5A and in_ready=0000.
  - After out_ready=1, the next beat appears the following cycle with no beat lost or duplicated.
- Reset mid-packet:
  - Assert rst_n=0 one cycle during a ch2 packet, then resume in mode 1 with ch0 and ch2 valid.
  - Required: busy=0 and out_valid=0 after the reset edge.
  - ptr=0, so ch0 is granted first.
